// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and helpers for the fetch-stage PC sequencer.
//   state_t : sequencer life-cycle state (BOOT -> RUN <-> HALT)
//   src_t   : which source feeds the next fetch PC
//   align_lo_mask() : mask of the PC bits that must be zero for an aligned target
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_REDIR,
    SRC_RET,
    SRC_TRAP,
    SRC_HOLD
  } src_t;

  // Low-bit mask for a power-of-two instruction size (4 -> 64'h3).
  function automatic logic [63:0] align_lo_mask(input int unsigned instr_bytes);
    return 64'(instr_bytes) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular return-address stack.
//   clk, reset      : clock, asynchronous active-low reset
//   push, push_data : push a return address (full stack overwrites the oldest entry)
//   pop             : drop the top entry (ignored while empty)
//   top             : current top entry (meaningless while empty)
//   empty           : no entries held
// The caller never asserts push and pop in the same cycle.
module pc_ras_stack #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   ptr;      // next slot to write; wraps, so a full push lands on the oldest entry
  logic [CW-1:0]   count;
  logic [PW-1:0]   top_idx;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (count != FULL) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer.
// Owns the fetch PC, picks the next PC (sequential / redirect / return / trap / hold),
// and tracks BOOT/RUN/HALT. Optional return-address stack under macro PC_SEQ_RAS_EN.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   stall                      : hold PC (does not block redirects or traps)
//   halt_req, resume           : enter / leave HALT
//   redirect_valid/_target     : taken branch or jump
//   redirect_is_call           : redirect is a call, push return address (RAS builds)
//   ret_req                    : predicted return, pop RAS (RAS builds)
//   trap_valid, trap_vector    : exception / interrupt entry
//   pc_out, fetch_valid        : current fetch PC and its validity
//   halted                     : in HALT
//   misalign_err, misalign_addr: one-cycle pulse and captured raw target on misaligned redirect/trap
//   ras_empty                  : RAS holds no entries (tied 1 without PC_SEQ_RAS_EN)
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            redirect_is_call,
  input  logic            ret_req,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] LO_MASK = XLEN'(align_lo_mask(INSTR_BYTES));
  localparam logic [XLEN-1:0] STEP    = XLEN'(INSTR_BYTES);

  state_t          state, state_n;
  src_t            src;
  logic [XLEN-1:0] seq_pc, tgt, pc_n, ras_top;
  logic            push, pop, ras_hit, call_ok, ras_emp, jump, mis;

  // Wraps modulo 2^XLEN by construction.
  assign seq_pc = pc_out + STEP;

`ifdef PC_SEQ_RAS_EN
  pc_ras_stack #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (seq_pc),
    .pop       (pop),
    .top       (ras_top),
    .empty     (ras_emp)
  );
  // A stalled return waits; a return on an empty stack falls through to halt/stall/seq.
  assign ras_hit = ret_req && !ras_emp && !stall;
  assign call_ok = redirect_is_call;
`else
  logic unused_ras;
  assign ras_top    = '0;
  assign ras_emp    = 1'b1;
  assign ras_hit    = 1'b0;
  assign call_ok    = 1'b0;
  assign unused_ras = ^{ret_req, redirect_is_call, push, pop};
`endif

  assign ras_empty = ras_emp;

  // Next state and PC source, priority trap > redirect > return > halt > stall > seq.
  always_comb begin
    state_n = state;
    src     = SRC_HOLD;
    push    = 1'b0;
    case (state)
      BOOT: state_n = RUN;  // RESET_VECTOR itself becomes the first fetch
      RUN: begin
        if (trap_valid) begin
          src = SRC_TRAP;
        end else if (redirect_valid) begin
          src  = SRC_REDIR;
          push = call_ok;
        end else if (ras_hit) begin
          src = SRC_RET;
        end else if (halt_req) begin
          state_n = HALT;
        end else if (!stall) begin
          src = SRC_SEQ;
        end
      end
      HALT: begin
        if (trap_valid) begin
          src     = SRC_TRAP;
          state_n = RUN;
        end else if (resume) begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  assign pop = (src == SRC_RET);

  always_comb begin
    tgt  = (src == SRC_TRAP) ? trap_vector : redirect_target;
    jump = (src == SRC_TRAP) || (src == SRC_REDIR);
    mis  = jump && |(tgt & LO_MASK);
    case (src)
      SRC_SEQ:             pc_n = seq_pc;
      SRC_RET:             pc_n = ras_top;
      SRC_TRAP, SRC_REDIR: pc_n = tgt & ~LO_MASK;  // misaligned targets are forced aligned
      default:             pc_n = pc_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= BOOT;
      pc_out        <= RESET_VECTOR;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state        <= state_n;
      pc_out       <= pc_n;
      misalign_err <= mis;
      if (mis) misalign_addr <= tgt;  // raw target, held until the next error
    end
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int          XLEN  = 64;
  localparam logic [63:0] RV    = 64'h1000;
  localparam int          IB    = 4;
  localparam int          DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam logic [63:0] LO = 64'(IB - 1);

  logic clk = 1'b0, reset = 1'b0;
  logic stall = 0, halt_req = 0, resume = 0, redirect_valid = 0, redirect_is_call = 0;
  logic ret_req = 0, trap_valid = 0;
  logic [63:0] redirect_target = '0, trap_vector = '0;
  logic [63:0] pc_out, misalign_addr;
  logic fetch_valid, halted, misalign_err, ras_empty;

  pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .INSTR_BYTES(IB), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .redirect_is_call(redirect_is_call), .ret_req(ret_req), .trap_valid(trap_valid),
    .trap_vector(trap_vector), .pc_out(pc_out), .fetch_valid(fetch_valid), .halted(halted),
    .misalign_err(misalign_err), .misalign_addr(misalign_addr), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model: mode 0=boot 1=run 2=halt, RAS as a queue (back = top).
  int          mmode;
  logic [63:0] mpc, maddr;
  logic        merr;
  logic [63:0] ras[$];

  task automatic m_reset();
    mmode = 0; mpc = RV; merr = 1'b0; maddr = '0; ras.delete();
  endtask

  task automatic m_take(input logic [63:0] t);
    mpc = t & ~LO;
    if ((t & LO) != 0) begin merr = 1'b1; maddr = t; end
  endtask

  task automatic m_edge();
    merr = 1'b0;
    if (mmode == 0) begin
      mmode = 1;
    end else if (mmode == 1) begin
      if (trap_valid) m_take(trap_vector);
      else if (redirect_valid) begin
        if (RAS_ON && redirect_is_call) begin
          ras.push_back(mpc + 64'(IB));
          if (ras.size() > DEPTH) ras.delete(0);
        end
        m_take(redirect_target);
      end
      else if (RAS_ON && ret_req && !stall && ras.size() > 0) mpc = ras.pop_back();
      else if (halt_req) mmode = 2;
      else if (!stall) mpc = mpc + 64'(IB);
    end else begin
      if (trap_valid) begin mmode = 1; m_take(trap_vector); end
      else if (resume) mmode = 1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, " pc"}, pc_out, mpc);
    check({ctx, " fetch_valid"}, 64'(fetch_valid), 64'(mmode == 1));
    check({ctx, " halted"}, 64'(halted), 64'(mmode == 2));
    check({ctx, " misalign_err"}, 64'(misalign_err), 64'(merr));
    check({ctx, " misalign_addr"}, misalign_addr, maddr);
    check({ctx, " ras_empty"}, 64'(ras_empty), 64'(RAS_ON ? (ras.size() == 0) : 1'b1));
  endtask

  task automatic idle();
    stall = 0; halt_req = 0; resume = 0; redirect_valid = 0; redirect_is_call = 0;
    ret_req = 0; trap_valid = 0;
  endtask

  task automatic cyc(input string ctx);
    m_edge();
    @(posedge clk); #1;
    check_all(ctx);
    idle();
  endtask

  task automatic redir(input logic [63:0] t, input logic call);
    redirect_valid = 1; redirect_target = t; redirect_is_call = call;
  endtask

  initial begin
    // Reset and boot
    m_reset();
    #12;
    check_all("reset");
    reset = 1'b1;
    #1;
    check_all("boot");
    cyc("run0");
    cyc("run1");
    check("first_seq pc", pc_out, 64'h1004);

    // Stall holds, redirect beats stall
    redir(64'h2000, 0); cyc("to2000");
    stall = 1; cyc("stall1");
    stall = 1; redir(64'h3000, 0); cyc("stall_redir");
    check("stall_redir pc", pc_out, 64'h3000);
    stall = 1; cyc("stall3");

    // Trap beats redirect, then misaligned redirect
    trap_valid = 1; trap_vector = 64'h8000; redir(64'h4000, 0); cyc("trap_pri");
    check("trap_pri pc", pc_out, 64'h8000);
    redir(64'h4002, 0); cyc("misalign");
    check("misalign pulse", 64'(misalign_err), 64'd1);
    cyc("misalign_after");

    // RAS: 5 calls into a 4-deep stack, then 5 returns
    redir(64'h100, 0); cyc("to100");
    for (int i = 1; i <= 5; i++) begin
      redir(64'((i + 1) * 'h100), 1); cyc("call");
    end
    for (int i = 0; i < 5; i++) begin
      ret_req = 1; cyc("ret");
    end

    // Halt / resume
    redir(64'h50, 0); cyc("to50");
    halt_req = 1; cyc("halt");
    redir(64'h900, 0); ret_req = 1; cyc("halt_ign");
    resume = 1; cyc("resume");
    cyc("resume_seq");

    // Async reset while halted with a pushed return address
    redir(64'h7FC, 1); cyc("call7fc");
    halt_req = 1; cyc("halt7fc");
    #2; reset = 1'b0; #1;
    m_reset();
    check_all("async_reset");
    #2; reset = 1'b1;
    cyc("reboot");

    // Wrap at top of address space
    redir(64'hFFFF_FFFF_FFFF_FFF8, 0); cyc("near_top");
    cyc("top");
    cyc("wrap");
    check("wrap pc", pc_out, 64'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [63:0] t;
      trap_valid = ($urandom_range(0, 99) < 5);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      trap_vector = t;
      redirect_valid = ($urandom_range(0, 99) < 20);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      redirect_target = t;
      redirect_is_call = $urandom_range(0, 1) == 1;
      ret_req = ($urandom_range(0, 99) < 25);
      halt_req = ($urandom_range(0, 99) < 5);
      resume = ($urandom_range(0, 99) < 30);
      stall = ($urandom_range(0, 99) < 25);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
